// File: rtl/argmax_classifier.sv
// Sequential argmax over the final dense layer's activations: captures the vector on start,
// scans one class per cycle and reports winning class, its score and the margin to the runner-up.
module argmax_classifier #(
  parameter int          CLASS_NB  = 10,
  parameter int          WIDTH_IN  = 32,
  parameter int          INDEX_W   = 4,
  parameter int unsigned MARGIN_TH = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         argmax_go,
  input  logic [WIDTH_IN*CLASS_NB-1:0] argmax_in,
  output logic [INDEX_W-1:0]           class_out,
  output logic [WIDTH_IN-1:0]          max_out,
  output logic [WIDTH_IN:0]            margin_out,
  output logic                         low_conf,
  output logic                         argmax_done
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_OUTPUT, S_DONE} state_t;

  localparam logic [WIDTH_IN:0]   TH      = (WIDTH_IN+1)'(MARGIN_TH);
  localparam logic [INDEX_W-1:0]  LAST    = INDEX_W'(CLASS_NB-1);
  localparam logic [WIDTH_IN-1:0] MOST_NEG = {1'b1, {(WIDTH_IN-1){1'b0}}};

  state_t state_q, state_d;

  logic [CLASS_NB-1:0][WIDTH_IN-1:0] buf_q, buf_d;
  logic signed [WIDTH_IN-1:0]        best_q, best_d, second_q, second_d, x;
  logic [INDEX_W-1:0]                idx_q, idx_d, cnt_q, cnt_d;
  logic [WIDTH_IN:0]                 diff;

  logic [INDEX_W-1:0]  class_q, class_d;
  logic [WIDTH_IN-1:0] max_q, max_d;
  logic [WIDTH_IN:0]   margin_q, margin_d;
  logic                lowc_q, lowc_d, done_q, done_d;

  logic load, scan_en, commit, release_done;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (argmax_go) state_d = S_SCAN;
      S_SCAN:   if (cnt_q == LAST) state_d = S_OUTPUT;
      S_OUTPUT: state_d = S_DONE;
      S_DONE:   if (!argmax_go) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM output decode (datapath strobes)
  always_comb begin
    load         = (state_q == S_IDLE) && argmax_go;
    scan_en      = (state_q == S_SCAN);
    commit       = (state_q == S_OUTPUT);
    release_done = (state_q == S_DONE) && !argmax_go;
  end

  // best >= second always holds, so the sign-extended difference is never negative
  assign diff = {best_q[WIDTH_IN-1], best_q} - {second_q[WIDTH_IN-1], second_q};
  assign x    = $signed(buf_q[cnt_q]);

  always_comb begin
    buf_d    = buf_q;
    best_d   = best_q;
    second_d = second_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    class_d  = class_q;
    max_d    = max_q;
    margin_d = margin_q;
    lowc_d   = lowc_q;
    done_d   = done_q;
    if (load) begin
      buf_d    = argmax_in;
      best_d   = $signed(argmax_in[WIDTH_IN-1:0]);
      second_d = $signed(MOST_NEG);
      idx_d    = '0;
      cnt_d    = INDEX_W'(1);
    end
    if (scan_en) begin
      // Strict compare: a tie with best leaves the lower index but pulls second up to best
      if (x > best_q) begin
        second_d = best_q;
        best_d   = x;
        idx_d    = cnt_q;
      end else if (x > second_q) begin
        second_d = x;
      end
      cnt_d = cnt_q + INDEX_W'(1);
    end
    if (commit) begin
      class_d  = idx_q;
      max_d    = best_q;
      margin_d = diff;
      lowc_d   = (diff <= TH);
      done_d   = 1'b1;
    end
    if (release_done) done_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q    <= '0;
      best_q   <= '0;
      second_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      class_q  <= '0;
      max_q    <= '0;
      margin_q <= '0;
      lowc_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      best_q   <= best_d;
      second_q <= second_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      class_q  <= class_d;
      max_q    <= max_d;
      margin_q <= margin_d;
      lowc_q   <= lowc_d;
      done_q   <= done_d;
    end
  end

  assign class_out   = class_q;
  assign max_out     = max_q;
  assign margin_out  = margin_q;
  assign low_conf    = lowc_q;
  assign argmax_done = done_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: expected results queued at start, checked on done.
module tb_argmax_classifier;
  localparam int CN = 10;
  localparam int W  = 32;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            argmax_go;
  logic [W*CN-1:0] argmax_in;
  logic [IW-1:0]   class_out;
  logic [W-1:0]    max_out;
  logic [W:0]      margin_out;
  logic            low_conf;
  logic            argmax_done;

  argmax_classifier #(.CLASS_NB(CN), .WIDTH_IN(W), .INDEX_W(IW), .MARGIN_TH(0)) dut (
    .clk(clk), .reset(reset), .argmax_go(argmax_go), .argmax_in(argmax_in),
    .class_out(class_out), .max_out(max_out), .margin_out(margin_out),
    .low_conf(low_conf), .argmax_done(argmax_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] cls;
    logic [W-1:0]  mx;
    logic [W:0]    margin;
    logic          lowc;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   checks = 0;
  int   failures = 0;
  int   vals [CN];
  logic done_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [W*CN-1:0] pack_vals();
    logic [W*CN-1:0] v;
    for (int i = 0; i < CN; i++) v[i*W +: W] = vals[i];
    return v;
  endfunction

  // Reference: lowest-index maximum, runner-up = largest of all other elements
  function automatic exp_t model(input logic [W*CN-1:0] v);
    exp_t e;
    int bi = 0;
    longint b, s, t;
    b = longint'($signed(v[W-1:0]));
    for (int i = 1; i < CN; i++) begin
      t = longint'($signed(v[i*W +: W]));
      if (t > b) begin b = t; bi = i; end
    end
    s = -(64'sd1 <<< (W-1));
    for (int i = 0; i < CN; i++) begin
      t = longint'($signed(v[i*W +: W]));
      if (i != bi && t > s) s = t;
    end
    e.cls    = IW'(bi);
    e.mx     = W'(b);
    e.margin = (W+1)'(b - s);
    e.lowc   = ((b - s) <= 0);
    return e;
  endfunction

  // Monitor: every rising done pops one expectation
  always @(negedge clk) begin
    if (argmax_done && !done_prev) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("class_out", 64'(class_out), 64'(e.cls));
        chk("max_out", 64'(max_out), 64'(e.mx));
        chk("margin_out", 64'(margin_out), 64'(e.margin));
        chk("low_conf", 64'(low_conf), 64'(e.lowc));
      end
    end
    done_prev <= argmax_done;
  end

  // Caller is at a negedge; returns just after the go-sampling edge
  task automatic start(input logic [W*CN-1:0] v);
    argmax_in = v;
    argmax_go = 1'b1;
    last_exp  = model(v);
    sb.push_back(last_exp);
    @(posedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (!argmax_done && n < 30);
    chk("latency", 64'(n), 64'd10);
  endtask

  task automatic drop_go();
    @(negedge clk); argmax_go = 1'b0;
    @(posedge clk); #1;
    chk("done_drop", 64'(argmax_done), 64'd0);
    chk("hold_class", 64'(class_out), 64'(last_exp.cls));
    chk("hold_margin", 64'(margin_out), 64'(last_exp.margin));
  endtask

  logic [W*CN-1:0] v1, vcap;

  initial begin
    reset = 1'b1; argmax_go = 1'b0; argmax_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_class", 64'(class_out), 64'd0);
    chk("rst_max", 64'(max_out), 64'd0);
    chk("rst_margin", 64'(margin_out), 64'd0);
    chk("rst_lowc", 64'(low_conf), 64'd0);
    chk("rst_done", 64'(argmax_done), 64'd0);
    reset = 1'b0;

    // Distinct values, go held past done
    vals = '{5, -3, 12, 0, 7, 1, 2, 40, 9, -8};
    v1 = pack_vals();
    @(negedge clk); start(v1); wait_done();
    chk("s1_class_const", 64'(class_out), 64'd7);
    chk("s1_margin_const", 64'(margin_out), 64'd28);
    repeat (3) begin
      @(posedge clk); #1;
      chk("done_held", 64'(argmax_done), 64'd1);
    end
    drop_go();

    // Tie between elements 3 and 5
    vals = '{10, 20, -5, 100, 49, 100, 0, 3, 7, 1};
    @(negedge clk); start(pack_vals()); wait_done();
    chk("tie_low_conf", 64'(low_conf), 64'd1);
    drop_go();

    // All negative
    vals = '{-10, -2, -7, -2, -50, -100, -100, -100, -100, -100};
    @(negedge clk); start(pack_vals()); wait_done();
    drop_go();

    // Extremes
    for (int i = 0; i < CN; i++) vals[i] = 32'sh80000000;
    vals[9] = 32'sh7fffffff;
    @(negedge clk); start(pack_vals()); wait_done();
    chk("ext_margin_const", 64'(margin_out), 64'hFFFF_FFFF);
    drop_go();

    // Input changes after capture must not matter
    for (int i = 0; i < CN; i++) vals[i] = i - 20;
    vals[0] = 1000;
    vcap = pack_vals();
    @(negedge clk); start(v1);
    @(negedge clk); argmax_in = vcap;
    wait_done();
    drop_go();

    // Re-trigger with a random vector
    for (int i = 0; i < CN; i++) vals[i] = int'($urandom_range(0, 2000)) - 1000;
    @(negedge clk); start(pack_vals()); wait_done();
    drop_go();

    // Reset mid-scan, then fresh start on the first edge after release
    @(negedge clk); start(v1);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    chk("mrst_class", 64'(class_out), 64'd0);
    chk("mrst_max", 64'(max_out), 64'd0);
    chk("mrst_margin", 64'(margin_out), 64'd0);
    chk("mrst_lowc", 64'(low_conf), 64'd0);
    chk("mrst_done", 64'(argmax_done), 64'd0);
    @(negedge clk); reset = 1'b0; argmax_go = 1'b0;
    start(v1); wait_done();
    drop_go();

    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
